// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the multicycle MIPS control unit
// Contents:
//   state_t  - main FSM states
//   OP_*     - instr[31:26] opcodes that the control unit recognises
//   FUNCT_*  - instr[5:0] R-type function codes
//   ALU_*    - 3-bit operation codes understood by the datapath ALU
//   alu_op_t - coarse ALU request from the FSM to the ALU decoder
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALU operation decoder
// Ports:
//   alu_op      in  coarse request from the main FSM (ADD, SUB or follow funct)
//   funct       in  instr[5:0]
//   alu_control out 3-bit ALU operation code
//   funct_valid out 1 when funct is one of the supported R-type functions
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    logic [2:0] funct_ctl;

    // funct_valid is decoded regardless of alu_op so the FSM can reject an
    // unknown R-type function already in DECODE, before EXECUTE is entered.
    always_comb begin
        funct_ctl   = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FUNCT_ADD: funct_ctl = ALU_ADD;
            FUNCT_SUB: funct_ctl = ALU_SUB;
            FUNCT_AND: funct_ctl = ALU_AND;
            FUNCT_OR:  funct_ctl = ALU_OR;
            FUNCT_SLT: funct_ctl = ALU_SLT;
            default: begin
                funct_ctl   = ALU_ADD;
                funct_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multicycle MIPS datapath
// Parameters:
//   ADDI_EN     1 = addi executes, 0 = addi is rejected as an illegal opcode
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   opcode      instr[31:26] from the instruction register
//   funct       instr[5:0] from the instruction register
//   zero        ALU zero flag, qualifies the branch PC update
//   mem_write   memory write enable
//   ir_write    instruction register enable
//   i_or_d      memory address select (0 PC, 1 ALUOut)
//   reg_write   register file write enable
//   reg_dst     write register select (0 rt, 1 rd)
//   mem_to_reg  write data select (0 ALUOut, 1 memory data)
//   alu_src_a   ALU A select (0 PC, 1 register A)
//   alu_src_b   ALU B select (00 B, 01 four, 10 sign-ext imm, 11 shifted imm)
//   pc_src      next PC select (00 ALU result, 01 ALUOut, 10 jump target)
//   alu_control ALU operation code
//   pc_en       PC enable
//   illegal_op  one-cycle pulse in DECODE for an unsupported instruction
module multicycle_control #(
    parameter bit ADDI_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       mem_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       pc_en,
    output logic       illegal_op
);

    import mips_ctrl_pkg::*;

    state_t  state;
    state_t  state_next;
    alu_op_t alu_op;
    logic    pc_write;
    logic    branch;
    logic    funct_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;

        case (state)
            FETCH: begin
                // PC + 4 goes straight from the ALU into the PC while the
                // instruction is latched.
                ir_write   = 1'b1;
                alu_src_b  = 2'b01;
                pc_write   = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE: begin
                        if (funct_valid) begin
                            state_next = EXECUTE;
                        end else begin
                            illegal_op = 1'b1;
                        end
                    end
                    OP_BEQ: state_next = BRANCH;
                    OP_ADDI: begin
                        if (ADDI_EN) begin
                            state_next = ADDIEX;
                        end else begin
                            illegal_op = 1'b1;
                        end
                    end
                    OP_J:    state_next = JUMP;
                    default: illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                i_or_d     = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                state_next = FETCH;
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_SUB;
                pc_src     = 2'b01;
                branch     = 1'b1;
                state_next = FETCH;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            default: begin
                // Unused encodings recover to FETCH with every enable low.
                state_next = FETCH;
            end
        endcase
    end

    assign pc_en = pc_write | (branch & zero);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control),
        .funct_valid (funct_valid)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    typedef struct packed {
        logic       mem_write;
        logic       ir_write;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       pc_en;
        logic       illegal_op;
    } ctl_t;

    localparam int S_FETCH    = 0;
    localparam int S_DECODE   = 1;
    localparam int S_DEC_ILL  = 2;
    localparam int S_MEMADR   = 3;
    localparam int S_MEMREAD  = 4;
    localparam int S_MEMWB    = 5;
    localparam int S_MEMWRITE = 6;
    localparam int S_EXECUTE  = 7;
    localparam int S_ALUWB    = 8;
    localparam int S_BRANCH   = 9;
    localparam int S_ADDIEX   = 10;
    localparam int S_ADDIWB   = 11;
    localparam int S_JUMP     = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       mem_write, ir_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       pc_en, illegal_op;

    logic       mem_write0, ir_write0, i_or_d0, reg_write0, reg_dst0, mem_to_reg0, alu_src_a0;
    logic [1:0] alu_src_b0, pc_src0;
    logic [2:0] alu_control0;
    logic       pc_en0, illegal_op0;

    ctl_t obs, obs0;
    assign obs  = {mem_write, ir_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a,
                   alu_src_b, pc_src, alu_control, pc_en, illegal_op};
    assign obs0 = {mem_write0, ir_write0, i_or_d0, reg_write0, reg_dst0, mem_to_reg0, alu_src_a0,
                   alu_src_b0, pc_src0, alu_control0, pc_en0, illegal_op0};

    always #5 clk = ~clk;

    multicycle_control #(.ADDI_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_write(mem_write), .ir_write(ir_write), .i_or_d(i_or_d),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_control(alu_control), .pc_en(pc_en), .illegal_op(illegal_op)
    );

    multicycle_control #(.ADDI_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_write(mem_write0), .ir_write(ir_write0), .i_or_d(i_or_d0),
        .reg_write(reg_write0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .pc_src(pc_src0),
        .alu_control(alu_control0), .pc_en(pc_en0), .illegal_op(illegal_op0)
    );

    int    checks   = 0;
    int    failures = 0;
    ctl_t  exp_q[$];
    ctl_t  exp0_q[$];
    string tag_q[$];

    // Expected output vector for one state, built from the control table.
    function automatic ctl_t ev(int st, logic [2:0] ctl, logic z);
        ctl_t c;
        c = '0;
        c.alu_control = 3'b010;
        case (st)
            S_FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.pc_en = 1'b1; end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_DEC_ILL:  begin c.alu_src_b = 2'b11; c.illegal_op = 1'b1; end
            S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMREAD:  c.i_or_d = 1'b1;
            S_MEMWB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWRITE: begin c.i_or_d = 1'b1; c.mem_write = 1'b1; end
            S_EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_control = ctl; end
            S_ALUWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_control = 3'b110;
                              c.pc_src = 2'b01; c.pc_en = z; end
            S_ADDIEX:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDIWB:   c.reg_write = 1'b1;
            S_JUMP:     begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    task automatic push(int st, int st0, string tag, logic [2:0] ctl = 3'b010, logic z = 1'b0);
        exp_q.push_back(ev(st, ctl, z));
        exp0_q.push_back(ev(st0, ctl, z));
        tag_q.push_back(tag);
    endtask

    // Samples 1 time unit after the falling edge, then waits for the next one.
    task automatic step();
        ctl_t  e, e0;
        string t;
        #1;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=%h expected=<queued entry>", obs);
        end else begin
            e  = exp_q.pop_front();
            e0 = exp0_q.pop_front();
            t  = tag_q.pop_front();
            checks++;
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s addi_en=1 observed=%h expected=%h", t, obs, e);
            end
            checks++;
            assert (obs0 === e0) else begin
                failures++;
                $error("FAIL %s addi_en=0 observed=%h expected=%h", t, obs0, e0);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 64;
        while (exp_q.size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $error("FAIL drain_budget observed=%0d expected=0 entries left", exp_q.size());
            exp_q.delete();
            exp0_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        logic [5:0] fn_tab [5];
        logic [2:0] ctl_tab[5];
        fn_tab  = '{6'b100010, 6'b101010, 6'b100000, 6'b100100, 6'b100101};
        ctl_tab = '{3'b110, 3'b111, 3'b010, 3'b000, 3'b001};

        reset  = 1'b1;
        opcode = 6'b100011;
        funct  = 6'b000000;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // lw: five cycles, then back in FETCH
        opcode = 6'b100011;
        push(S_FETCH,   S_FETCH,   "reset_fetch");
        push(S_DECODE,  S_DECODE,  "lw_decode");
        push(S_MEMADR,  S_MEMADR,  "lw_memadr");
        push(S_MEMREAD, S_MEMREAD, "lw_memread");
        push(S_MEMWB,   S_MEMWB,   "lw_memwb");
        drain();

        // R-type functions
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            push(S_FETCH,   S_FETCH,   "r_fetch");
            push(S_DECODE,  S_DECODE,  "r_decode");
            push(S_EXECUTE, S_EXECUTE, $sformatf("r_exec_%b", fn_tab[i]), ctl_tab[i]);
            push(S_ALUWB,   S_ALUWB,   "r_aluwb");
            drain();
        end

        // beq taken then not taken
        opcode = 6'b000100;
        funct  = 6'b000000;
        for (int i = 0; i < 2; i++) begin
            zero = (i == 0);
            push(S_FETCH,  S_FETCH,  "beq_fetch", 3'b010, zero);
            push(S_DECODE, S_DECODE, "beq_decode", 3'b010, zero);
            push(S_BRANCH, S_BRANCH, $sformatf("beq_branch_z%0d", zero), 3'b010, zero);
            drain();
        end
        zero = 1'b0;

        // sw then j
        opcode = 6'b101011;
        push(S_FETCH,    S_FETCH,    "sw_fetch");
        push(S_DECODE,   S_DECODE,   "sw_decode");
        push(S_MEMADR,   S_MEMADR,   "sw_memadr");
        push(S_MEMWRITE, S_MEMWRITE, "sw_memwrite");
        drain();
        opcode = 6'b000010;
        push(S_FETCH,  S_FETCH,  "j_fetch");
        push(S_DECODE, S_DECODE, "j_decode");
        push(S_JUMP,   S_JUMP,   "j_jump");
        drain();

        // addi: executes with ADDI_EN=1, rejected twice with ADDI_EN=0
        opcode = 6'b001000;
        push(S_FETCH,  S_FETCH,   "addi_fetch");
        push(S_DECODE, S_DEC_ILL, "addi_decode");
        push(S_ADDIEX, S_FETCH,   "addi_ex");
        push(S_ADDIWB, S_DEC_ILL, "addi_wb");
        drain();

        // illegal opcode and illegal R-type funct
        opcode = 6'b111111;
        push(S_FETCH,   S_FETCH,   "illop_fetch");
        push(S_DEC_ILL, S_DEC_ILL, "illop_decode");
        drain();
        opcode = 6'b000000;
        funct  = 6'b000111;
        push(S_FETCH,   S_FETCH,   "illfn_fetch");
        push(S_DEC_ILL, S_DEC_ILL, "illfn_decode");
        drain();

        // reset while in MEMREAD of a lw
        opcode = 6'b100011;
        funct  = 6'b000000;
        push(S_FETCH,  S_FETCH,  "rst_lw_fetch");
        push(S_DECODE, S_DECODE, "rst_lw_decode");
        push(S_MEMADR, S_MEMADR, "rst_lw_memadr");
        drain();
        reset = 1'b1;
        push(S_MEMREAD, S_MEMREAD, "rst_lw_memread");
        drain();
        reset = 1'b0;
        push(S_FETCH,  S_FETCH,  "rst_after_fetch");
        push(S_DECODE, S_DECODE, "rst_after_decode");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
